calc_seq: RTL and testbench
===========================

// Module: calc_seq
// PURPOSE
//  Sequencer for the two-operand calculator. Debounces the OK/CLR buttons and
//  latches operand A and operand B from the switches. Runs one ALU operation
//  and produces the estate/mem1/mem2/result bus that the display output
//  controller consumes: 00=A, 01=A+B, 10=A+B+result, 11=blank/error.
// PARAMETERS
//  DEB_CYCLES  20'd500000  consecutive stable cycles required to accept a button level change
//  CNT_W       20          width of each debounce counter; must hold DEB_CYCLES
// PORTS
//  clk      in   1  system clock; all state updates on posedge
//  rst_n    in   1  asynchronous reset, active-low
//  sw       in   8  operand switches, asynchronous to clk, unsigned
//  op       in   2  operation select: 00 add, 01 sub, 10 mul, 11 and
//  btn_ok   in   1  confirm button, raw, active-high
//  btn_clr  in   1  clear button, raw, active-high
//  estate   out  2  display state code for the output controller
//  mem1     out  8  operand A
//  mem2     out  8  operand B
//  result   out  8  low 8 bits of the operation
//  ovf      out  1  overflow/underflow of the last operation
//  op_lat   out  2  op value latched with operand B
// BEHAVIOUR
//  Reset (rst_n=0, async): FSM=S_A, all outputs 0, sync FFs 0, deb counters 0.
//  Input conditioning:
//   - Each button passes through a 2-FF synchronizer.
//   - Debounce: the counter counts while sync level != accepted level and
//     resets to 0 whenever they match.
//   - At count==DEB_CYCLES-1 the accepted level flips and the counter clears.
//   - A 0->1 flip of the accepted level gives a 1-cycle pulse (ok_p/clr_p).
//   - One pulse per press; a held button never repeats.
//   - Press-to-pulse latency = 2 + DEB_CYCLES cycles; FSM acts on the next edge.
//  FSM (internal state -> estate):
//   S_A(00):
//    - mem1 <= sw every cycle (live display).
//    - ok_p -> S_B; mem1 keeps the sw value sampled on that cycle.
//   S_B(01):
//    - mem2 <= sw every cycle.
//    - ok_p: mem2 <= sw, op_lat <= op, -> S_CALC.
//   S_CALC(01):
//    - Exactly 1 cycle; buttons are ignored.
//    - Computes result and ovf, then -> S_SHOW if ovf=0, else -> S_ERR.
//   S_SHOW(10):
//    - mem1, mem2, result, ovf held.
//    - ok_p: mem2, result, ovf, op_lat <= 0, -> S_A.
//   S_ERR(11):
//    - Display blanked; result holds the truncated value; ovf=1.
//    - ok_p or clr_p -> S_A with the same clears as S_SHOW.
//  clr_p in any state except S_CALC:
//   - -> S_A; mem2, result, ovf, op_lat <= 0.
//   - mem1 resumes tracking sw on the next cycle.
//  clr_p pending in S_CALC is applied on the following cycle, never dropped.
//  ok_p and clr_p in the same cycle: clr wins.
//  Arithmetic (unsigned, evaluated in S_CALC on mem1/mem2/op_lat):
//   - add: 9-bit sum; result = sum[7:0]; ovf = sum[8].
//   - sub: result = mem1-mem2 mod 256; ovf = (mem2 > mem1).
//   - mul: 16-bit product; result = p[7:0]; ovf = |p[15:8].
//   - and: result = mem1 & mem2; ovf = 0.
//  Outputs are registered; estate changes on the same edge as the FSM state.
//  Reset mid-operation (any state, including S_CALC) returns to the reset values immediately.
// TESTING (DEB_CYCLES=4 in bench)
//  1. reset, sw=8'd7, wait -> estate=00, mem1=7, mem2=0, result=0, ovf=0.
//  2. ok press (8 cyc), sw=5, ok, op=00 -> estate 00->01->01(CALC)->10; result=12, ovf=0.
//  3. A=200, B=100, op=00 -> estate=11, ovf=1, result=44; then ok -> estate=00, mem2=0.
//  4. A=3, B=9, op=01 -> estate=11, ovf=1, result=250.
//     A=16, B=16, op=10 -> ovf=1, result=0.
//     A=15, B=15, op=10 -> estate=10, result=225.
//  5. Bounce: ok toggles every 2 cycles for 20 cycles -> no pulse, estate stays 00.
//     Hold 30 cycles -> exactly one transition.
//  6. In S_B, ok and clr pressed together -> estate=00, mem2=0.
//     rst_n low in S_SHOW -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/calc_seq.sv
// Two-operand calculator sequencer: button conditioning, operand latching,
// one-cycle ALU evaluation and the display state bus.
module calc_seq #(
    parameter int unsigned          CNT_W      = 20,
    parameter logic [CNT_W-1:0]     DEB_CYCLES = 20'd500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic [1:0] op,
    input  logic       btn_ok,
    input  logic       btn_clr,
    output logic [1:0] estate,
    output logic [7:0] mem1,
    output logic [7:0] mem2,
    output logic [7:0] result,
    output logic       ovf,
    output logic [1:0] op_lat
);

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_CALC,
        S_SHOW,
        S_ERR
    } state_t;

    state_t state, state_n;

    // Index 0 = OK button, index 1 = CLR button.
    logic [1:0]       sync1, sync2, acc, pulse;
    logic [CNT_W-1:0] cnt [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            acc   <= '0;
            pulse <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= {btn_clr, btn_ok};
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] != acc[i]) begin
                    if (cnt[i] == DEB_CYCLES - 1'b1) begin
                        acc[i]   <= sync2[i];
                        cnt[i]   <= '0;
                        pulse[i] <= sync2[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    logic ok_p, clr_p, clr_eff;
    assign ok_p  = pulse[0];
    assign clr_p = pulse[1];

    logic       clr_pend, clr_pend_n;
    logic [7:0] mem1_n, mem2_n, result_n;
    logic       ovf_n;
    logic [1:0] op_lat_n, estate_n;

    logic [8:0]  sum;
    logic [15:0] prod;
    logic        calc_ovf;
    logic [7:0]  calc_res;

    assign sum  = {1'b0, mem1} + {1'b0, mem2};
    assign prod = mem1 * mem2;

    always_comb begin
        calc_res = '0;
        calc_ovf = 1'b0;
        unique case (op_lat)
            2'b00: begin calc_res = sum[7:0];      calc_ovf = sum[8];      end
            2'b01: begin calc_res = mem1 - mem2;   calc_ovf = mem2 > mem1; end
            2'b10: begin calc_res = prod[7:0];     calc_ovf = |prod[15:8]; end
            2'b11: begin calc_res = mem1 & mem2;   calc_ovf = 1'b0;        end
            default: ;
        endcase
    end

    // A clear arriving during S_CALC is parked in clr_pend and honoured one cycle later.
    assign clr_eff = clr_p | clr_pend;

    always_comb begin
        state_n    = state;
        mem1_n     = mem1;
        mem2_n     = mem2;
        result_n   = result;
        ovf_n      = ovf;
        op_lat_n   = op_lat;
        clr_pend_n = 1'b0;
        unique case (state)
            S_A: begin
                mem1_n = sw;
                if (clr_eff) begin
                    mem2_n   = '0;
                    result_n = '0;
                    ovf_n    = 1'b0;
                    op_lat_n = '0;
                end else if (ok_p) begin
                    state_n = S_B;
                end
            end
            S_B: begin
                mem2_n = sw;
                if (clr_eff) begin
                    state_n  = S_A;
                    mem2_n   = '0;
                    result_n = '0;
                    ovf_n    = 1'b0;
                    op_lat_n = '0;
                end else if (ok_p) begin
                    op_lat_n = op;
                    state_n  = S_CALC;
                end
            end
            S_CALC: begin
                result_n   = calc_res;
                ovf_n      = calc_ovf;
                clr_pend_n = clr_p;
                state_n    = calc_ovf ? S_ERR : S_SHOW;
            end
            S_SHOW, S_ERR: begin
                if (clr_eff || ok_p) begin
                    state_n  = S_A;
                    mem2_n   = '0;
                    result_n = '0;
                    ovf_n    = 1'b0;
                    op_lat_n = '0;
                end
            end
            default: state_n = S_A;
        endcase
    end

    always_comb begin
        estate_n = 2'b00;
        unique case (state_n)
            S_A:          estate_n = 2'b00;
            S_B, S_CALC:  estate_n = 2'b01;
            S_SHOW:       estate_n = 2'b10;
            S_ERR:        estate_n = 2'b11;
            default:      estate_n = 2'b11;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_A;
            clr_pend <= 1'b0;
            estate   <= '0;
            mem1     <= '0;
            mem2     <= '0;
            result   <= '0;
            ovf      <= 1'b0;
            op_lat   <= '0;
        end else begin
            state    <= state_n;
            clr_pend <= clr_pend_n;
            estate   <= estate_n;
            mem1     <= mem1_n;
            mem2     <= mem2_n;
            result   <= result_n;
            ovf      <= ovf_n;
            op_lat   <= op_lat_n;
        end
    end

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq with a scoreboard of expected operation results.
module tb_calc_seq;

    logic       clk, rst_n;
    logic [7:0] sw;
    logic [1:0] op;
    logic       btn_ok, btn_clr;
    logic [1:0] estate;
    logic [7:0] mem1, mem2, result;
    logic       ovf;
    logic [1:0] op_lat;

    calc_seq #(.CNT_W(20), .DEB_CYCLES(20'd4)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .op(op),
        .btn_ok(btn_ok), .btn_clr(btn_clr),
        .estate(estate), .mem1(mem1), .mem2(mem2),
        .result(result), .ovf(ovf), .op_lat(op_lat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] est;
        logic [7:0] m1;
        logic [7:0] m2;
        logic [7:0] res;
        logic       ovf;
        logic [1:0] opl;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] est_log[$];
    logic [1:0] last_est;
    int         total, passed;

    initial last_est = 2'b00;
    always @(negedge clk) begin
        if (rst_n && estate !== last_est) begin
            est_log.push_back(estate);
            last_est = estate;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic press(input bit ok, input bit clr, input int hold);
        btn_ok  = ok;
        btn_clr = clr;
        repeat (hold) @(negedge clk);
        btn_ok  = 1'b0;
        btn_clr = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic push_exp(input string tag, input int a, input int b, input int o);
        exp_t e;
        int   r;
        bit   v;
        case (o)
            0:       begin r = a + b;             v = (r > 255); end
            1:       begin r = (a - b + 256);     v = (b > a);   end
            2:       begin r = a * b;             v = (r > 255); end
            default: begin r = a & b;             v = 1'b0;      end
        endcase
        e.tag = tag;
        e.res = r[7:0];
        e.ovf = v;
        e.est = v ? 2'b11 : 2'b10;
        e.m1  = a[7:0];
        e.m2  = b[7:0];
        e.opl = o[1:0];
        sb.push_back(e);
    endtask

    task automatic do_op(input string tag, input int a, input int b, input int o);
        exp_t e;
        int   budget;
        sw = a[7:0];
        op = 2'b00;
        repeat (2) @(negedge clk);
        press(1'b1, 1'b0, 8);
        chk({tag, "_est_B"}, estate, 2'b01);
        chk({tag, "_memA"}, mem1, a[7:0]);
        sw = b[7:0];
        op = o[1:0];
        push_exp(tag, a, b, o);
        press(1'b1, 1'b0, 8);
        budget = 40;
        while (estate[1] !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        e = sb.pop_front();
        chk({e.tag, "_estate"}, estate, e.est);
        chk({e.tag, "_result"}, result, e.res);
        chk({e.tag, "_ovf"},    ovf,    e.ovf);
        chk({e.tag, "_mem1"},   mem1,   e.m1);
        chk({e.tag, "_mem2"},   mem2,   e.m2);
        chk({e.tag, "_op_lat"}, op_lat, e.opl);
    endtask

    task automatic ack(input string tag, input bit use_clr);
        press(!use_clr, use_clr, 8);
        chk({tag, "_ack_est"},    estate, 2'b00);
        chk({tag, "_ack_mem2"},   mem2,   8'd0);
        chk({tag, "_ack_result"}, result, 8'd0);
        chk({tag, "_ack_ovf"},    ovf,    1'b0);
        chk({tag, "_ack_oplat"},  op_lat, 2'b00);
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        rst_n   = 1'b0;
        sw      = 8'd7;
        op      = 2'b00;
        btn_ok  = 1'b0;
        btn_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_estate", estate, 2'b00);
        chk("rst_mem1",   mem1,   8'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_estate", estate, 2'b00);
        chk("idle_mem1",   mem1,   8'd7);
        chk("idle_mem2",   mem2,   8'd0);
        chk("idle_result", result, 8'd0);
        chk("idle_ovf",    ovf,    1'b0);

        est_log.delete();
        do_op("add_7_5", 7, 5, 0);
        chk("seq_len", est_log.size(), 2);
        if (est_log.size() == 2) begin
            chk("seq_0", est_log[0], 2'b01);
            chk("seq_1", est_log[1], 2'b10);
        end
        ack("add_7_5", 1'b0);

        do_op("add_ovf", 200, 100, 0);
        ack("add_ovf", 1'b0);
        do_op("sub_unf", 3, 9, 1);
        ack("sub_unf", 1'b0);
        do_op("mul_ovf", 16, 16, 2);
        ack("mul_ovf", 1'b0);
        do_op("mul_ok", 15, 15, 2);
        ack("mul_ok", 1'b0);
        do_op("and", 8'hF0, 8'h3C, 3);
        ack("and", 1'b0);
        do_op("sub_ok", 100, 40, 1);
        ack("sub_ok", 1'b1);

        est_log.delete();
        for (int i = 0; i < 10; i++) begin
            btn_ok = ~btn_ok;
            repeat (2) @(negedge clk);
        end
        btn_ok = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_log", est_log.size(), 0);
        chk("bounce_est", estate, 2'b00);

        est_log.delete();
        press(1'b1, 1'b0, 30);
        chk("hold_log", est_log.size(), 1);
        chk("hold_est", estate, 2'b01);

        sw = 8'h55;
        repeat (2) @(negedge clk);
        chk("b_track_mem2", mem2, 8'h55);
        press(1'b1, 1'b1, 8);
        chk("okclr_est",  estate, 2'b00);
        chk("okclr_mem2", mem2,   8'd0);
        chk("okclr_mem1", mem1,   8'h55);

        do_op("mul_rst", 15, 15, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_estate", estate, 2'b00);
        chk("arst_mem1",   mem1,   8'd0);
        chk("arst_mem2",   mem2,   8'd0);
        chk("arst_result", result, 8'd0);
        chk("arst_ovf",    ovf,    1'b0);
        chk("arst_oplat",  op_lat, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_est", estate, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
